fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues sequential 16-bit fetches, buffers
// returned words in an output entry plus a one-entry skid, and handles redirects.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic        imem_read,
  output logic [15:0] imem_address,
  output logic        if_valid,
  output logic [15:0] if_ir,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2
);

  typedef enum logic {
    S_RUN,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_req_addr;
  logic        r_req_busy;
  logic        r_out_valid;
  logic [15:0] r_out_ir;
  logic [15:0] r_out_pc;
  logic        r_skid_valid;
  logic [15:0] r_skid_ir;
  logic [15:0] r_skid_pc;

  state_t      w_state_nxt;
  logic [15:0] w_pc_nxt;
  logic [15:0] w_req_addr_nxt;
  logic        w_req_busy_nxt;
  logic        w_out_valid_nxt;
  logic [15:0] w_out_ir_nxt;
  logic [15:0] w_out_pc_nxt;
  logic        w_skid_valid_nxt;
  logic [15:0] w_skid_ir_nxt;
  logic [15:0] w_skid_pc_nxt;
  logic        w_consume;
  logic        w_done;
  logic        w_accept;

  assign w_consume = r_out_valid & ~stall;
  assign w_done    = r_req_busy & imem_resp;
  assign w_accept  = w_done & (r_state == S_RUN);

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_addr_nxt   = r_req_addr;
    w_req_busy_nxt   = r_req_busy;
    w_out_valid_nxt  = r_out_valid;
    w_out_ir_nxt     = r_out_ir;
    w_out_pc_nxt     = r_out_pc;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_ir_nxt    = r_skid_ir;
    w_skid_pc_nxt    = r_skid_pc;

    if (redirect) begin
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
      w_pc_nxt         = redirect_pc;
      // A request still in flight must complete before the new target can issue.
      if (r_req_busy && !imem_resp) begin
        w_state_nxt = S_DRAIN;
      end else begin
        w_req_busy_nxt = 1'b0;
        w_state_nxt    = S_RUN;
      end
    end else begin
      if (w_done) begin
        w_req_busy_nxt = 1'b0;
        w_state_nxt    = S_RUN;
      end
      if (w_accept && (!r_out_valid || w_consume)) begin
        w_out_valid_nxt = 1'b1;
        w_out_ir_nxt    = imem_rdata;
        w_out_pc_nxt    = r_req_addr;
      end else if (w_consume) begin
        w_out_valid_nxt  = r_skid_valid;
        w_skid_valid_nxt = 1'b0;
        if (r_skid_valid) begin
          w_out_ir_nxt = r_skid_ir;
          w_out_pc_nxt = r_skid_pc;
        end
      end
      if (w_accept && r_out_valid && !w_consume) begin
        w_skid_valid_nxt = 1'b1;
        w_skid_ir_nxt    = imem_rdata;
        w_skid_pc_nxt    = r_req_addr;
      end
    end

    // Issue in the same edge a response retires so imem_read re-asserts next cycle.
    if (!w_req_busy_nxt && !w_skid_valid_nxt) begin
      w_req_busy_nxt = 1'b1;
      w_req_addr_nxt = w_pc_nxt;
      w_pc_nxt       = w_pc_nxt + 16'd2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_RUN;
      r_pc         <= RESET_PC;
      r_req_addr   <= '0;
      r_req_busy   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_ir     <= '0;
      r_out_pc     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ir    <= '0;
      r_skid_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_req_busy   <= w_req_busy_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_ir     <= w_out_ir_nxt;
      r_out_pc     <= w_out_pc_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_ir    <= w_skid_ir_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
    end
  end

  assign imem_read    = r_req_busy;
  assign imem_address = r_req_addr;
  assign if_valid     = r_out_valid;
  assign if_ir        = r_out_ir;
  assign if_pc        = r_out_pc;
  assign if_pc_plus2  = r_out_pc + 16'd2;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, randomized run against a
// queue-based fetch model, and an asynchronous reset-during-request sequence.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        if_valid;
  logic [15:0] if_ir;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;

  int unsigned errors = 0;
  int unsigned checks = 0;

  fetch_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall        (stall),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .if_valid     (if_valid),
    .if_ir        (if_ir),
    .if_pc        (if_pc),
    .if_pc_plus2  (if_pc_plus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [15:0] rpc;
    logic        stl;
    logic        resp;
    logic [15:0] rdata;
    logic        e_read;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_ir;
    logic [15:0] e_pc;
  } vec_t;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
  } ent_t;

  vec_t vecs [25];

  // Fetch model: fetched words form a FIFO of at most two (presented + held).
  logic        m_busy;
  logic        m_drain;
  logic [15:0] m_addr;
  logic [15:0] m_pc;
  ent_t        m_q [$];

  function automatic vec_t v(input logic redir, input logic [15:0] rpc,
                             input logic stl, input logic resp, input logic [15:0] rdata,
                             input logic e_read, input logic [15:0] e_addr,
                             input logic e_valid, input logic [15:0] e_ir,
                             input logic [15:0] e_pc);
    vec_t r;
    r.redir = redir; r.rpc = rpc; r.stl = stl; r.resp = resp; r.rdata = rdata;
    r.e_read = e_read; r.e_addr = e_addr; r.e_valid = e_valid;
    r.e_ir = e_ir; r.e_pc = e_pc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic e_read, input logic [15:0] e_addr,
                     input logic e_valid, input logic [15:0] e_ir, input logic [15:0] e_pc,
                     input logic force_data);
    logic        ok;
    logic [15:0] e_pc2;
    ok    = 1'b1;
    e_pc2 = e_pc + 16'd2;
    if (imem_read !== e_read) ok = 1'b0;
    if (e_read && (imem_address !== e_addr)) ok = 1'b0;
    if (if_valid !== e_valid) ok = 1'b0;
    if ((e_valid || force_data) &&
        ((if_ir !== e_ir) || (if_pc !== e_pc) || (if_pc_plus2 !== e_pc2))) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got read=%b addr=%h valid=%b ir=%h pc=%h pc2=%h ; want read=%b addr=%h valid=%b ir=%h pc=%h pc2=%h",
               nm, imem_read, imem_address, if_valid, if_ir, if_pc, if_pc_plus2,
               e_read, e_addr, e_valid, e_ir, e_pc, e_pc2);
    end
  endtask

  task automatic clear_inputs();
    redirect    = 1'b0;
    redirect_pc = '0;
    stall       = 1'b0;
    imem_resp   = 1'b0;
    imem_rdata  = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
    reset_n  = 1'b1;
    m_busy   = 1'b0;
    m_drain  = 1'b0;
    m_addr   = '0;
    m_pc     = 16'h0000;
    m_q.delete();
  endtask

  task automatic model_step();
    logic consume;
    logic done;
    consume = (m_q.size() > 0) && !stall;
    done    = m_busy && imem_resp;
    if (redirect) begin
      m_q.delete();
      m_pc = redirect_pc;
      if (m_busy && !done) m_drain = 1'b1;
      else begin
        m_busy  = 1'b0;
        m_drain = 1'b0;
      end
    end else begin
      if (consume) void'(m_q.pop_front());
      if (done) begin
        if (!m_drain) m_q.push_back('{ir: imem_rdata, pc: m_addr});
        m_busy  = 1'b0;
        m_drain = 1'b0;
      end
    end
    if (!m_busy && (m_q.size() <= 1)) begin
      m_busy = 1'b1;
      m_addr = m_pc;
      m_pc   = m_pc + 16'd2;
    end
  endtask

  task automatic model_chk(input string nm);
    logic        e_valid;
    logic [15:0] e_ir;
    logic [15:0] e_pc;
    e_valid = (m_q.size() > 0);
    e_ir    = e_valid ? m_q[0].ir : 16'h0000;
    e_pc    = e_valid ? m_q[0].pc : 16'h0000;
    chk(nm, m_busy, m_addr, e_valid, e_ir, e_pc, 1'b0);
  endtask

  initial begin
    vecs[0]  = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    vecs[1]  = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    vecs[2]  = v(0, 16'h0000, 0, 1, 16'hA000, 1, 16'h0002, 1, 16'hA000, 16'h0000);
    vecs[3]  = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 0, 16'h0000, 16'h0000);
    vecs[4]  = v(0, 16'h0000, 0, 1, 16'hA002, 1, 16'h0004, 1, 16'hA002, 16'h0002);
    vecs[5]  = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0004, 0, 16'h0000, 16'h0000);
    vecs[6]  = v(0, 16'h0000, 0, 1, 16'hA004, 1, 16'h0006, 1, 16'hA004, 16'h0004);
    vecs[7]  = v(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0006, 1, 16'hA004, 16'h0004);
    vecs[8]  = v(0, 16'h0000, 1, 1, 16'hA006, 0, 16'h0000, 1, 16'hA004, 16'h0004);
    vecs[9]  = v(0, 16'h0000, 1, 1, 16'hBEEF, 0, 16'h0000, 1, 16'hA004, 16'h0004);
    vecs[10] = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0008, 1, 16'hA006, 16'h0006);
    vecs[11] = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0008, 0, 16'h0000, 16'h0000);
    vecs[12] = v(1, 16'h3000, 0, 0, 16'h0000, 1, 16'h0008, 0, 16'h0000, 16'h0000);
    vecs[13] = v(0, 16'h0000, 0, 1, 16'hDEAD, 1, 16'h3000, 0, 16'h0000, 16'h0000);
    vecs[14] = v(1, 16'h4000, 0, 1, 16'h1111, 1, 16'h4000, 0, 16'h0000, 16'h0000);
    vecs[15] = v(1, 16'h1000, 0, 0, 16'h0000, 1, 16'h4000, 0, 16'h0000, 16'h0000);
    vecs[16] = v(1, 16'h2000, 0, 0, 16'h0000, 1, 16'h4000, 0, 16'h0000, 16'h0000);
    vecs[17] = v(0, 16'h0000, 0, 1, 16'h2222, 1, 16'h2000, 0, 16'h0000, 16'h0000);
    vecs[18] = v(1, 16'hFFFE, 0, 0, 16'h0000, 1, 16'h2000, 0, 16'h0000, 16'h0000);
    vecs[19] = v(0, 16'h0000, 0, 1, 16'h3333, 1, 16'hFFFE, 0, 16'h0000, 16'h0000);
    vecs[20] = v(0, 16'h0000, 0, 1, 16'h7777, 1, 16'h0000, 1, 16'h7777, 16'hFFFE);
    vecs[21] = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    vecs[22] = v(0, 16'h0000, 0, 1, 16'h8888, 1, 16'h0002, 1, 16'h8888, 16'h0000);
    vecs[23] = v(1, 16'h5000, 1, 0, 16'h0000, 1, 16'h0002, 0, 16'h0000, 16'h0000);
    vecs[24] = v(0, 16'h0000, 0, 1, 16'h9999, 1, 16'h5000, 0, 16'h0000, 16'h0000);

    do_reset();
    for (int i = 0; i < 25; i++) begin
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      stall       = vecs[i].stl;
      imem_resp   = vecs[i].resp;
      imem_rdata  = vecs[i].rdata;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), vecs[i].e_read, vecs[i].e_addr, vecs[i].e_valid,
          vecs[i].e_ir, vecs[i].e_pc, 1'b0);
    end

    do_reset();
    for (int c = 0; c < 2000; c++) begin
      redirect    = ($urandom_range(0, 99) < 7);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
      stall       = ($urandom_range(0, 99) < 35);
      imem_resp   = m_busy ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 10);
      imem_rdata  = 16'($urandom);
      @(posedge clk);
      model_step();
      #1;
      model_chk($sformatf("rand%0d", c));
    end

    // Guarantee an outstanding request, then reset asynchronously mid-request.
    clear_inputs();
    repeat (2) begin
      @(posedge clk);
      model_step();
      #1;
      model_chk("pre_reset");
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
    imem_resp  = 1'b1;
    imem_rdata = 16'hCAFE;
    @(posedge clk);
    #1;
    chk("reset_held_resp", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_stale_resp", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
    imem_resp = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_hold", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
